// File: rtl/control_sequencer.sv
// control_sequencer
//   Moore-style control unit for a small accumulator-less RISC datapath.
//   Walks a three-step fetch (T0..T2) and then up to five execute steps
//   (T3..T7) chosen by the opcode in IR[31:27]. Memory steps stall on
//   mem_ready. A halt opcode, or stop seen in T0, parks the FSM in HALTED
//   until clear is asserted.
// Ports
//   clock      system clock, rising edge
//   clear      asynchronous active-low reset
//   IR         instruction register contents (opcode = IR[31:27])
//   mem_ready  completes the current Read/Write in this cycle
//   stop       halt request, looked at only in T0
//   PCout, MDRout, Zlowout, CSignOut, Rout   bus-drive selects
//   MARin, MDRin, IRin, PCin, IncPC, Yin, ZLowIn, Rin   register loads
//   Gra, Grb, Grc   register-field selects
//   Read, Write     memory strobes
//   alu_op          ALU operation (zero unless ZLowIn)
//   run             high in T0..T7
//   illegal         one-cycle pulse in T3 on an undefined opcode
module control_sequencer (
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] IR,
  input  logic        mem_ready,
  input  logic        stop,
  output logic        PCout,
  output logic        MDRout,
  output logic        Zlowout,
  output logic        CSignOut,
  output logic        Rout,
  output logic        MARin,
  output logic        MDRin,
  output logic        IRin,
  output logic        PCin,
  output logic        IncPC,
  output logic        Yin,
  output logic        ZLowIn,
  output logic        Rin,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Read,
  output logic        Write,
  output logic [4:0]  alu_op,
  output logic        run,
  output logic        illegal
);

  typedef enum logic [3:0] {
    S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALTED
  } state_t;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  state_t     state;
  logic [4:0] opcode;
  logic       is_alu, is_addi, is_ld, is_st, is_nop, is_halt, is_exec;

  // Register fields are consumed by the datapath, not here.
  logic unused_fields;
  assign unused_fields = ^IR[26:0];

  assign opcode  = IR[31:27];
  assign is_alu  = (opcode == OP_ADD) || (opcode == OP_SUB) ||
                   (opcode == OP_AND) || (opcode == OP_OR);
  assign is_addi = (opcode == OP_ADDI);
  assign is_ld   = (opcode == OP_LD);
  assign is_st   = (opcode == OP_ST);
  assign is_nop  = (opcode == OP_NOP);
  assign is_halt = (opcode == OP_HALT);
  // Opcodes that run the T3..T5 execute steps.
  assign is_exec = is_alu || is_addi || is_ld || is_st;

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state <= S_RST;
    end else begin
      case (state)
        S_RST:    state <= S_T0;
        S_T0:     state <= stop ? S_HALTED : S_T1;
        S_T1:     state <= mem_ready ? S_T2 : S_T1;
        S_T2: begin
          if (is_nop)       state <= S_T0;
          else if (is_halt) state <= S_HALTED;
          else              state <= S_T3;
        end
        S_T3:     state <= is_exec ? S_T4 : S_T0;
        S_T4:     state <= S_T5;
        S_T5:     state <= (is_ld || is_st) ? S_T6 : S_T0;
        S_T6: begin
          if (is_ld) state <= mem_ready ? S_T7 : S_T6;
          else       state <= S_T7;
        end
        S_T7: begin
          if (is_ld) state <= S_T0;
          else       state <= mem_ready ? S_T0 : S_T7;
        end
        S_HALTED: state <= S_HALTED;
        default:  state <= S_RST;
      endcase
    end
  end

  // Outputs decode straight from the state register and IR. They are not
  // pre-registered because IR itself is reloaded on the T2 exit edge, so
  // execute-step outputs must see the IR value present during that step.
  // Because state resets asynchronously, every output (Read/Write included)
  // drops the moment clear goes low.
  always_comb begin
    PCout    = 1'b0;
    MDRout   = 1'b0;
    Zlowout  = 1'b0;
    CSignOut = 1'b0;
    Rout     = 1'b0;
    MARin    = 1'b0;
    MDRin    = 1'b0;
    IRin     = 1'b0;
    PCin     = 1'b0;
    IncPC    = 1'b0;
    Yin      = 1'b0;
    ZLowIn   = 1'b0;
    Rin      = 1'b0;
    Gra      = 1'b0;
    Grb      = 1'b0;
    Grc      = 1'b0;
    Read     = 1'b0;
    Write    = 1'b0;
    alu_op   = 5'b00000;
    run      = 1'b0;
    illegal  = 1'b0;
    case (state)
      S_T0: begin
        run = 1'b1;
        // A stop request suppresses the fetch strobes so the PC is not
        // advanced on the way into HALTED.
        PCout = !stop;
        MARin = !stop;
        IncPC = !stop;
      end
      S_T1: begin
        run   = 1'b1;
        Read  = 1'b1;
        MDRin = 1'b1;
      end
      S_T2: begin
        run    = 1'b1;
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      S_T3: begin
        run = 1'b1;
        if (is_exec) begin
          Grb  = 1'b1;
          Rout = 1'b1;
          Yin  = 1'b1;
        end else begin
          illegal = 1'b1;
        end
      end
      S_T4: begin
        run    = 1'b1;
        ZLowIn = 1'b1;
        if (is_alu) begin
          Grc    = 1'b1;
          Rout   = 1'b1;
          alu_op = opcode;
        end else begin
          // addi and ld/st address: Rb + sign-extended constant
          CSignOut = 1'b1;
          alu_op   = OP_ADD;
        end
      end
      S_T5: begin
        run     = 1'b1;
        Zlowout = 1'b1;
        if (is_ld || is_st) begin
          MARin = 1'b1;
        end else begin
          Gra = 1'b1;
          Rin = 1'b1;
        end
      end
      S_T6: begin
        run   = 1'b1;
        MDRin = 1'b1;
        if (is_ld) begin
          Read = 1'b1;
        end else begin
          Gra  = 1'b1;
          Rout = 1'b1;
        end
      end
      S_T7: begin
        run = 1'b1;
        if (is_ld) begin
          MDRout = 1'b1;
          Gra    = 1'b1;
          Rin    = 1'b1;
        end else begin
          Write = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule
